mul_seq_nbit: RTL
=================

MUL_SEQ_NBIT -- requirements
Module: mul_seq_nbit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning operand width in bits; legal range 2..64.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port start  input  1  request to begin a multiply; sampled on a rising edge of clk.
REQ-005 SHALL provide port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL provide port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL provide port b  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL provide port busy  output  1  high while an operation is in progress.
REQ-009 SHALL provide port done  output  1  one-cycle pulse when hi/lo become valid.
REQ-010 SHALL provide port hi  output  WIDTH  upper half of the 2*WIDTH-bit product.
REQ-011 SHALL provide port lo  output  WIDTH  lower half of the 2*WIDTH-bit product.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIXUP, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance, latch a, b and is_signed, clear the accumulator and the bit counter, and enter RUN.
REQ-014 SHALL ignore start in RUN or FIXUP; latched operands and progress are unaffected.
REQ-015 SHALL, in signed mode, latch |a| and |b| as WIDTH-bit unsigned magnitudes, plus a negate flag = a[WIDTH-1] XOR b[WIDTH-1]; in unsigned mode, magnitudes = raw operands and negate = 0.
REQ-016 SHALL, in each RUN cycle, add the magnitude of a to the upper accumulator when the current LSB of the multiplier is 1, then shift {carry, accumulator} right by one bit (shift-add, one multiplier bit per cycle).
REQ-017 SHALL stay in RUN for exactly WIDTH cycles, counted by a ceil(log2(WIDTH+1))-bit counter, then enter FIXUP.
REQ-018 SHALL, in FIXUP, two's-complement negate the full 2*WIDTH-bit product if the negate flag is set, load hi/lo, then enter DONE.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE; DONE returns to IDLE unless a new start is accepted.
REQ-020 SHALL make done visible WIDTH+2 rising edges after the edge that accepts start.
REQ-021 SHALL assert busy in RUN and FIXUP only; busy is low in IDLE and DONE.
REQ-022 SHALL hold hi/lo stable from DONE until the next FIXUP load; accepting a new start SHALL NOT alter hi/lo before that load.
REQ-023 SHALL produce the exact product for every operand pair, with no overflow. This includes signed (-2^(WIDTH-1)) * (-2^(WIDTH-1)) = 2^(2*WIDTH-2).
REQ-024 SHALL treat a zero operand like any other operand: full latency, product 0, no early termination.

Reset
REQ-025 SHALL, when rst_n = 0 at a rising edge, force state IDLE, busy = 0, done = 0, hi = 0, lo = 0, and clear the counter, accumulator and negate flag.
REQ-026 SHALL give reset priority over start at the same edge; an operation in progress is abandoned without a done pulse.

Verification (WIDTH = 4)
REQ-027 SHALL pass: unsigned a=3, b=5 -> done 6 edges after start; hi=0x0, lo=0xF; busy high for 5 cycles.
REQ-028 SHALL pass: unsigned a=0xF, b=0xF -> hi=0xE, lo=0x1.
REQ-029 SHALL pass: signed a=0x8, b=0x8 -> hi=0x4, lo=0x0; signed a=0xF, b=0x1 -> hi=0xF, lo=0xF.
REQ-030 SHALL pass: start pulsed again with a=7, b=7 during RUN -> ignored; the first result completes unchanged and only one done pulse occurs.
REQ-031 SHALL pass: rst_n low for one cycle mid-RUN -> busy=0, hi/lo=0 next edge, no done; a fresh 2*3 then yields lo=0x6.
REQ-032 SHALL pass: back-to-back start held high in the DONE cycle -> second op accepted; prior hi/lo held until its FIXUP; done pulses every 6 cycles.

Source files
------------

// File: rtl/mul_seq_nbit.sv
// mul_seq_nbit: sequential shift-add multiplier, one multiplier bit per cycle.
// Signed operands are multiplied as magnitudes. The sign is applied in a single
// FIXUP cycle, so the most negative value times itself does not overflow.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a multiply; accepted only in IDLE or DONE
//   is_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b       multiplicand / multiplier (sampled with start)
//   busy       high in RUN and FIXUP
//   done       one-cycle pulse while in DONE
//   hi, lo     upper / lower halves of the 2*WIDTH-bit product
//
// state | meaning
// IDLE  | waiting for start
// RUN   | WIDTH shift-add steps, one multiplier bit each
// FIXUP | apply the sign to the product and load hi/lo
// DONE  | result valid, done pulse; start may be accepted here
module mul_seq_nbit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    // Upper half is the running accumulator. Lower half starts as |b| and
    // shifts out one multiplier bit per step.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
        abs_b = (is_signed && b[WIDTH-1]) ? -b : b;
        // The carry is kept in sum[WIDTH] and shifts into the accumulator.
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + ({(WIDTH+1){acc_q[0]}} & {1'b0, mag_a_q});
        prod_fix = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_a_d = mag_a_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    mag_a_d = abs_a;
                    acc_d   = {{WIDTH{1'b0}}, abs_b};
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy  = 1'b1;
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                busy    = 1'b1;
                hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                lo_d    = prod_fix[WIDTH-1:0];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_a_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_a_q <= mag_a_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
